charmatrix_renderer: RTL and testbench
======================================

Name: charmatrix_renderer

Overview:
- Parametrised successor to the fixed 4-character serial matrix renderer.
- Accepts a byte stream (UART RX side) into a circular text buffer of BUF_DEPTH characters, each stored with a colour index sampled at write time.
- Once per refresh period, streams NUM_CHARS glyphs of CHAR_W x CHAR_H pixels as 24-bit colour words to the ws2812b driver.
- Adds CR handling, buffer clear on reset, window offset, frame status outputs and optional scrolling.

Parameters:
NUM_CHARS, 4, characters displayed per frame (>=1)
BUF_DEPTH, 8, text buffer entries; power of two, >= NUM_CHARS
CHAR_W, 5, glyph columns
CHAR_H, 7, glyph rows; CHAR_LEDS = CHAR_W*CHAR_H
REFRESH_DIV, 131072, clk cycles between frame triggers
FILL_CHAR, 8'h20, buffer contents after reset
SCROLL_DIV, 16, frames per scroll step (only with scroll feature)

Ports:
clk  in  1  system clock (20 MHz)
rst_n  in  1  synchronous active-low reset
in_data  in  8  received byte
in_valid  in  1  byte available
in_ready  out  1  block accepts byte
color_in  in  4  colour index latched with each byte (from LFSR)
char_addr  out  8  glyph ROM address (registered)
char_data  in  CHAR_LEDS  glyph bits; combinational ROM, valid the cycle after char_addr changes
color_addr  out  4  colour ROM address (registered)
color_data  in  24  GRB colour word
px_data  out  24  pixel to LED driver
px_valid  out  1  pixel valid
px_latch  out  1  high with last pixel of the frame
px_ready  in  1  LED driver ready
frame_busy  out  1  frame in progress
frame_drop  out  1  one-cycle pulse: trigger arrived while busy

Behaviour:
- Reset is synchronous: when rst_n=0 at a clk edge, all buffer entries <= FILL_CHAR, all colours <= 0, write pointer <= 0, window offset <= 0, refresh counter <= 0, state <= IDLE.
  - Outputs held at reset values: in_ready=0, px_valid=0, px_latch=0, px_data=0, char_addr=0, color_addr=0, frame_busy=0, frame_drop=0.
- Reset mid-frame abandons the frame immediately with no further px_valid.
- Input:
  - in_ready=1 in every cycle after reset. Accept on in_valid&in_ready.
  - Byte 8'h0D (CR): sets wptr <= 0 and is not stored.
  - Any other byte: buf[wptr] <= in_data, col[wptr] <= color_in, wptr <= wptr+1 (mod BUF_DEPTH; wraps, overwriting the oldest entry).
  - A write to an entry in the same cycle it is read returns the old value.
- Refresh:
  - The counter counts 0..REFRESH_DIV-1 and wraps. The trigger fires when count==REFRESH_DIV-1.
  - A trigger arriving in a non-IDLE state is dropped, and frame_drop pulses for that cycle.
- FSM:
  - IDLE: char_addr/color_addr <= entry (offset+0). On trigger -> FETCH.
  - FETCH: one cycle for ROM settle -> LOAD. frame_busy=1 in every non-IDLE state.
  - LOAD: px_data <= char_data[bit] ? color_data : 0. px_latch <= (led_idx == NUM_CHARS*CHAR_LEDS-1). -> WAIT_READY.
  - WAIT_READY: when px_ready=1, px_valid <= 1 and indices advance.
    - If bit == CHAR_LEDS-1: bit <= 0, ch <= ch+1, and the ROM addresses are updated to entry (offset+ch+1) mod BUF_DEPTH.
    - -> WAIT_STARTED.
  - WAIT_STARTED: when px_ready=0, px_valid <= 0. If pixels remain -> LOAD, else -> IDLE. px_latch clears on IDLE entry.
  - If the address changed on the last step, the next LOAD passes through FETCH first.
- Pixel order: character-major, glyph bit 0 first. Exactly NUM_CHARS*CHAR_LEDS px_valid pulses per frame.
- Index widths: sized with $clog2, no truncation for the maximum parameter values.

Optional Feature:
- Macro: CHARMATRIX_SCROLL_EN.
- Defined: the window offset increments (mod BUF_DEPTH) after every SCROLL_DIV completed frames.
  - The frame counter counts only frames that finish; dropped triggers are not counted.
  - The offset is never changed mid-frame.
- Undefined: offset is constant 0, and the SCROLL_DIV logic is absent.

Decomposition:
- Package charmatrix_pkg: FSM state encoding, CR code constant, colour word width (24), colour index width (4).
- One sub-module: charmatrix_textbuf. It holds the circular char/colour storage, write pointer and CR handling, and exposes a combinational read port indexed by (offset+ch).

Test Plan:
- Reset, default params, no input, px_ready modelled as driver: first frame emits 140 pixels, all px_data=0 (FILL_CHAR space glyph blank); px_latch high only on pixel 140; frame_busy low afterwards.
- Send "0123", with color_in=3 for each: buf[0..3]="0123", wptr=0 after wrap mod 8 only after 8 writes (here wptr=4). Pixels of char 0 equal colour-ROM[3] where glyph '0' bits are 1, else 0.
- Send "AB", 0x0D, "C": buf[0]='C', buf[1]='B', wptr=1; 0x0D is never stored.
- Hold px_ready=1 for 2*REFRESH_DIV cycles mid-frame (stalled driver): exactly one frame_drop pulse per missed trigger; the frame resumes with no duplicated or lost pixel.
- Assert rst_n=0 for one cycle at pixel 50: next cycle px_valid=0 and state=IDLE, and the next frame starts from pixel 0 with buffer = FILL_CHAR.
- With CHARMATRIX_SCROLL_EN, SCROLL_DIV=2, buffer "ABCDEFGH": frames 1-2 show "ABCD", frames 3-4 show "BCDE"; after 8 steps the offset wraps and "HABC" appears at offset 7.

Source files
------------

// File: rtl/charmatrix_pkg.sv
// Shared types and constants for the character-matrix renderer: FSM state
// encoding, the carriage-return code and colour widths.
package charmatrix_pkg;

  localparam int COLOR_W = 24;  // GRB colour word
  localparam int CIDX_W  = 4;   // colour ROM index

  localparam logic [7:0] CR_CODE = 8'h0D;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_WAIT_READY,
    S_WAIT_STARTED
  } state_t;

endpackage

// File: rtl/charmatrix_textbuf.sv
// Circular text buffer: one character and one colour index per entry, a
// wrapping write pointer reset by CR, and a combinational read port.
module charmatrix_textbuf
  import charmatrix_pkg::*;
#(
  parameter int         BUF_DEPTH = 8,
  parameter logic [7:0] FILL_CHAR = 8'h20,
  localparam int        PTR_W     = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  input  logic              in_ready,
  input  logic [CIDX_W-1:0] color_in,
  input  logic [PTR_W-1:0]  rd_idx,
  output logic [7:0]        rd_char,
  output logic [CIDX_W-1:0] rd_color
);

  logic [7:0]        char_mem  [BUF_DEPTH];
  logic [CIDX_W-1:0] color_mem [BUF_DEPTH];
  logic [PTR_W-1:0]  wptr;
  logic              accept;

  assign accept = in_valid & in_ready;

  // NOTE: the storage is reset like ordinary flops because the display must
  // show FILL_CHAR after reset; that keeps it out of a RAM macro, which is
  // acceptable at this depth.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        char_mem[i]  <= FILL_CHAR;
        color_mem[i] <= '0;
      end
    end else if (accept) begin
      if (in_data == CR_CODE) begin
        wptr <= '0;
      end else begin
        char_mem[wptr]  <= in_data;
        color_mem[wptr] <= color_in;
        wptr            <= wptr + PTR_W'(1);
      end
    end
  end

  // A same-cycle write is seen by the reader only on the following cycle.
  assign rd_char  = char_mem[rd_idx];
  assign rd_color = color_mem[rd_idx];

endmodule

// File: rtl/charmatrix_renderer.sv
// Serial character-matrix renderer: buffers received text and, once per
// refresh period, streams NUM_CHARS glyphs as GRB pixels to the LED driver.
// Define CHARMATRIX_SCROLL_EN to advance the window every SCROLL_DIV frames.
module charmatrix_renderer
  import charmatrix_pkg::*;
#(
`ifdef CHARMATRIX_SCROLL_EN
  parameter int         SCROLL_DIV  = 16,
`endif
  parameter int         NUM_CHARS   = 4,
  parameter int         BUF_DEPTH   = 8,
  parameter int         CHAR_W      = 5,
  parameter int         CHAR_H      = 7,
  parameter int         REFRESH_DIV = 131072,
  parameter logic [7:0] FILL_CHAR   = 8'h20,
  localparam int        CHAR_LEDS   = CHAR_W * CHAR_H
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CIDX_W-1:0]    color_in,
  output logic [7:0]           char_addr,
  input  logic [CHAR_LEDS-1:0] char_data,
  output logic [CIDX_W-1:0]    color_addr,
  input  logic [COLOR_W-1:0]   color_data,
  output logic [COLOR_W-1:0]   px_data,
  output logic                 px_valid,
  output logic                 px_latch,
  input  logic                 px_ready,
  output logic                 frame_busy,
  output logic                 frame_drop
);

  localparam int TOTAL = NUM_CHARS * CHAR_LEDS;
  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int BIT_W = (CHAR_LEDS > 1) ? $clog2(CHAR_LEDS) : 1;
  localparam int CH_W  = $clog2(NUM_CHARS + 1);
  localparam int LED_W = $clog2(TOTAL + 1);
  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  refresh_cnt;
  logic              trigger;
  logic [BIT_W-1:0]  bit_idx;
  logic [CH_W-1:0]   ch_idx;
  logic [LED_W-1:0]  led_idx;
  logic              refetch;
  logic              last_bit;
  logic [PTR_W-1:0]  offset;
  logic [PTR_W-1:0]  rd_idx;
  logic [7:0]        rd_char;
  logic [CIDX_W-1:0] rd_color;

  charmatrix_textbuf #(
    .BUF_DEPTH (BUF_DEPTH),
    .FILL_CHAR (FILL_CHAR)
  ) u_textbuf (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .color_in (color_in),
    .rd_idx   (rd_idx),
    .rd_char  (rd_char),
    .rd_color (rd_color)
  );

  assign trigger    = (refresh_cnt == CNT_W'(REFRESH_DIV - 1));
  assign frame_busy = (state != S_IDLE);
  assign frame_drop = trigger & frame_busy;
  assign last_bit   = (bit_idx == BIT_W'(CHAR_LEDS - 1));

  // While a pixel is being handed off the port looks one character ahead,
  // so the address is ready when the current glyph is finished.
  assign rd_idx = offset + PTR_W'(ch_idx)
                + ((state == S_WAIT_READY) ? PTR_W'(1) : PTR_W'(0));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      refresh_cnt <= '0;
    end else if (trigger) begin
      refresh_cnt <= '0;
    end else begin
      refresh_cnt <= refresh_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // NOTE: state_nx gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:         if (trigger) state_nx = S_FETCH;
      S_FETCH:        state_nx = S_LOAD;
      S_LOAD:         state_nx = S_WAIT_READY;
      S_WAIT_READY:   if (px_ready) state_nx = S_WAIT_STARTED;
      S_WAIT_STARTED: begin
        if (!px_ready) begin
          if (px_latch)     state_nx = S_IDLE;
          else if (refetch) state_nx = S_FETCH;
          else              state_nx = S_LOAD;
        end
      end
      default:        state_nx = S_IDLE;
    endcase
  end

  // NOTE: all registered state uses non-blocking assignment so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_ready   <= 1'b0;
      char_addr  <= '0;
      color_addr <= '0;
      px_data    <= '0;
      px_valid   <= 1'b0;
      px_latch   <= 1'b0;
      bit_idx    <= '0;
      ch_idx     <= '0;
      led_idx    <= '0;
      refetch    <= 1'b0;
    end else begin
      in_ready <= 1'b1;
      case (state)
        S_IDLE: begin
          char_addr  <= rd_char;
          color_addr <= rd_color;
          bit_idx    <= '0;
          ch_idx     <= '0;
          led_idx    <= '0;
          refetch    <= 1'b0;
          px_valid   <= 1'b0;
          px_latch   <= 1'b0;
        end
        S_LOAD: begin
          px_data  <= char_data[bit_idx] ? color_data : '0;
          px_latch <= (led_idx == LED_W'(TOTAL - 1));
        end
        S_WAIT_READY: begin
          if (px_ready) begin
            px_valid <= 1'b1;
            led_idx  <= led_idx + LED_W'(1);
            if (last_bit) begin
              bit_idx    <= '0;
              ch_idx     <= ch_idx + CH_W'(1);
              char_addr  <= rd_char;
              color_addr <= rd_color;
              refetch    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + BIT_W'(1);
            end
          end
        end
        S_WAIT_STARTED: begin
          if (!px_ready) begin
            px_valid <= 1'b0;
            px_latch <= 1'b0;
            refetch  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CHARMATRIX_SCROLL_EN
  localparam int FRM_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

  logic [FRM_W-1:0] frame_cnt;

  // Counted on the hand-off of the latch pixel, so the offset only moves
  // between frames and abandoned or dropped frames never count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      offset    <= '0;
      frame_cnt <= '0;
    end else if (state == S_WAIT_STARTED && !px_ready && px_latch) begin
      if (frame_cnt == FRM_W'(SCROLL_DIV - 1)) begin
        frame_cnt <= '0;
        offset    <= offset + PTR_W'(1);
      end else begin
        frame_cnt <= frame_cnt + FRM_W'(1);
      end
    end
  end
`else
  assign offset = '0;
`endif

endmodule

// File: tb/tb_charmatrix_renderer.sv
// Self-checking bench for charmatrix_renderer: a handshaking LED-driver model
// pops pixels from a scoreboard filled from a text-buffer model per trigger.
`timescale 1ns/1ps
module tb_charmatrix_renderer;
  import charmatrix_pkg::*;

  localparam int NUM_CHARS = 4;
  localparam int BUF_DEPTH = 8;
  localparam int CHAR_LEDS = 35;
  localparam int DIV       = 1024;
  localparam int TOTAL     = NUM_CHARS * CHAR_LEDS;
  localparam int SDIV      = 2;

  typedef struct packed {
    logic [23:0] data;
    logic        latch;
  } px_t;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [7:0]           in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic [3:0]           color_in;
  logic [7:0]           char_addr;
  logic [CHAR_LEDS-1:0] char_data;
  logic [3:0]           color_addr;
  logic [23:0]          color_data;
  logic [23:0]          px_data;
  logic                 px_valid;
  logic                 px_latch;
  logic                 px_ready;
  logic                 frame_busy;
  logic                 frame_drop;

  always #25 clk = ~clk;

  function automatic logic [CHAR_LEDS-1:0] glyph(input logic [7:0] a);
    if (a == 8'h20) return '0;
    return {a, a ^ 8'h5A, a + 8'd7, ~a, 3'b101};
  endfunction

  function automatic logic [23:0] colour(input logic [3:0] i);
    return {i, 4'hA, ~i, 4'h5, i ^ 4'h9, 4'hC};
  endfunction

  assign char_data  = glyph(char_addr);
  assign color_data = colour(color_addr);

  charmatrix_renderer #(
`ifdef CHARMATRIX_SCROLL_EN
    .SCROLL_DIV  (SDIV),
`endif
    .NUM_CHARS   (NUM_CHARS),
    .BUF_DEPTH   (BUF_DEPTH),
    .CHAR_W      (5),
    .CHAR_H      (7),
    .REFRESH_DIV (DIV),
    .FILL_CHAR   (8'h20)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .color_in   (color_in),
    .char_addr  (char_addr),
    .char_data  (char_data),
    .color_addr (color_addr),
    .color_data (color_data),
    .px_data    (px_data),
    .px_valid   (px_valid),
    .px_latch   (px_latch),
    .px_ready   (px_ready),
    .frame_busy (frame_busy),
    .frame_drop (frame_drop)
  );

  logic [7:0] m_buf [BUF_DEPTH];
  logic [3:0] m_col [BUF_DEPTH];
  int  m_wptr = 0, m_off = 0, m_frames = 0, m_cnt = 0;
  px_t sb[$];
  int  checks = 0, failures = 0;
  int  pix_cnt = 0, obs_drops = 0, exp_drops = 0, stall_req = 0;
  logic busy_s = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame();
    for (int k = 0; k < NUM_CHARS; k++) begin
      int idx;
      logic [CHAR_LEDS-1:0] g;
      logic [23:0] c;
      idx = (m_off + k) % BUF_DEPTH;
      g   = glyph(m_buf[idx]);
      c   = colour(m_col[idx]);
      for (int b = 0; b < CHAR_LEDS; b++) begin
        px_t e;
        e.data  = g[b] ? c : 24'h0;
        e.latch = (k == NUM_CHARS - 1) && (b == CHAR_LEDS - 1);
        sb.push_back(e);
      end
    end
  endtask

  // Reference model: refresh counter, text-buffer reset, frame expectations.
  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        for (int i = 0; i < BUF_DEPTH; i++) begin
          m_buf[i] = 8'h20;
          m_col[i] = 4'h0;
        end
        m_wptr = 0; m_off = 0; m_frames = 0; m_cnt = 0;
        sb.delete();
      end else begin
        if (m_cnt == DIV - 1 && !busy_s) push_frame();
        m_cnt = (m_cnt == DIV - 1) ? 0 : m_cnt + 1;
      end
    end
  end

  // LED driver model and per-cycle drop monitor.
  initial begin
    bit waiting = 0;
    int stall_left = 0, delay = 0;
    px_t e;
    px_ready = 1'b1;
    forever begin
      @(negedge clk);
      busy_s = frame_busy;
      if (!rst_n) begin
        px_ready = 1'b1; waiting = 0; stall_left = 0;
      end else begin
        if (m_cnt == DIV - 1 || frame_drop) begin
          check("frame_drop", frame_drop, (m_cnt == DIV - 1) && frame_busy);
          if (frame_drop) obs_drops++;
          if (m_cnt == DIV - 1 && frame_busy) exp_drops++;
        end
        if (!waiting) begin
          if (px_valid && px_ready) begin
            pix_cnt++;
            check("px_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
              e = sb.pop_front();
              check("px_data", px_data, e.data);
              check("px_latch", px_latch, e.latch);
`ifdef CHARMATRIX_SCROLL_EN
              if (e.latch) begin
                m_frames++;
                if (m_frames == SDIV) begin
                  m_frames = 0;
                  m_off = (m_off + 1) % BUF_DEPTH;
                end
              end
`endif
            end
            waiting = 1;
            delay = $urandom_range(0, 2);
            if (stall_req > 0) begin
              stall_left = stall_req;
              stall_req = 0;
            end else begin
              px_ready = 1'b0;
            end
          end
        end else if (stall_left > 0) begin
          stall_left--;
          if (stall_left == 0) px_ready = 1'b0;
        end else if (!px_valid) begin
          if (delay > 0) delay--;
          else begin
            px_ready = 1'b1;
            waiting = 0;
          end
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic [3:0] c);
    in_data = b; in_valid = 1'b1; color_in = c;
    if (b == CR_CODE) m_wptr = 0;
    else begin
      m_buf[m_wptr] = b;
      m_col[m_wptr] = c;
      m_wptr = (m_wptr + 1) % BUF_DEPTH;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_str(input string s, input logic [3:0] c);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], c);
  endtask

  task automatic wait_busy(input string tag);
    int n = 0;
    while (!frame_busy && n < 3 * DIV) begin @(negedge clk); n++; end
    check({tag, "_start"}, frame_busy, 1);
  endtask

  task automatic run_frame(input string tag, input int stall_at);
    int n = 0;
    pix_cnt = 0;
    wait_busy(tag);
    if (stall_at >= 0) begin
      while (pix_cnt < stall_at && n < DIV) begin @(negedge clk); n++; end
      stall_req = 2 * DIV;
    end
    n = 0;
    while (frame_busy && n < 4 * DIV) begin @(negedge clk); n++; end
    check({tag, "_end"}, frame_busy, 0);
    check({tag, "_pixels"}, pix_cnt, TOTAL);
    check({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, e0, n;
    rst_n = 1'b0; in_data = 8'h0; in_valid = 1'b0; color_in = 4'h0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_px_valid", px_valid, 0);
    check("rst_px_latch", px_latch, 0);
    check("rst_px_data", px_data, 0);
    check("rst_char_addr", char_addr, 0);
    check("rst_color_addr", color_addr, 0);
    check("rst_frame_busy", frame_busy, 0);
    check("rst_frame_drop", frame_drop, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_reset", in_ready, 1);

    run_frame("blank", -1);

    send_str("0123", 4'd3);
    run_frame("digits", -1);

    send_byte("A", 4'd5);
    send_byte("B", 4'd6);
    send_byte(CR_CODE, 4'd7);
    send_byte("C", 4'd8);
    run_frame("cr", -1);
    send_byte("D", 4'd9);
    run_frame("cr_wptr", -1);

    d0 = obs_drops; e0 = exp_drops;
    run_frame("stall", 10);
    check("stall_drops", obs_drops - d0, exp_drops - e0);
    check("stall_drops_ge2", (obs_drops - d0) >= 2, 1);

    pix_cnt = 0;
    wait_busy("rstmid");
    n = 0;
    while (pix_cnt < 50 && n < DIV) begin @(negedge clk); n++; end
    check("rstmid_reached_50", pix_cnt >= 50, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rstmid_px_valid", px_valid, 0);
    check("rstmid_frame_busy", frame_busy, 0);
    check("rstmid_px_latch", px_latch, 0);
    rst_n = 1'b1;
    run_frame("post_reset", -1);

`ifdef CHARMATRIX_SCROLL_EN
    for (int i = 0; i < 8; i++) send_byte(8'h41 + 8'(i), 4'(i + 1));
    for (int f = 0; f < 18; f++) run_frame("scroll", -1);
`endif

    check("final_sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
